alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
- Clocked, width-parametrised successor of the team's 8-bit operator mux ALU.
- Holds operand registers A and B and result register Y; executes one operation per accepted `enable` strobe.
- Adds status flags, an iterative signed multiply, explicit busy/done/illegal handshaking and a 5-bit opcode space.
- Sits between the board switch/button front end (data_in, selector, enable) and the LED/display drivers (Y, ALed, BLed).

Parameters:
- WIDTH, 8, datapath width in bits for A, B, Y and data_in; must be at least 4.
- MUL_EN, 1, 1 enables the iterative multiply (op 17); 0 makes op 17 illegal.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  operation strobe; sampled on rising clk.
- selector  in  5  opcode.
- data_in  in  WIDTH  signed load data.
- Y  out  WIDTH  signed result register.
- ALed  out  WIDTH  continuous copy of register A.
- BLed  out  WIDTH  continuous copy of register B.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse when an accepted operation completes.
- illegal  out  1  high together with done when the completed opcode was illegal.
- flags  out  4  {N,Z,V,C}.

Behaviour:
- Reset (reset=0, asynchronous): A, B, Y, flags, busy, done and illegal all go to 0. The FSM goes to IDLE. Any multiply in progress is aborted with no done.
- FSM states:
  - IDLE: enable=1 at a rising edge is accepted.
  - MUL: iterating; enable is ignored, with no queuing.
- Single-cycle ops: accepted at edge k; registers update at edge k; done (and illegal if applicable) is high for exactly the cycle after edge k.
- Opcodes (all arithmetic is signed two's complement at WIDTH bits):
  - 0 ADD: Y=A+B. C=unsigned carry out; V=signed overflow.
  - 1 SUB: Y=A-B. C=1 when no borrow (A>=B unsigned); V=signed overflow.
  - 2 SHL: Y=A<<1. C=A[W-1]; V=A[W-1]^A[W-2].
  - 3 SAR: Y=A>>>1. C=A[0]; V=0.
  - 4 CMP: Y=0 if A==B, +1 if A>B, -1 if A<B (signed compare). C=V=0.
  - 5-10 logic: AND, OR, XOR, NAND, NOR, XNOR of A,B into Y. C=V=0.
  - 11 NOT: Y=~A. C=V=0.
  - 12 NEG: Y=-A. V=1 only when A=-2^(W-1); C=0.
  - 13 MOVYA: A<=Y.
  - 14 SWAP: A<=B and B<=A in the same edge.
  - 15 LDA: A<=data_in.
  - 16 LDB: B<=data_in.
  - 17 MUL: see below.
  - 18-31: illegal.
- N and Z are taken from the new Y value on every Y-writing op (0-12, 17).
- Ops 13-16 leave Y and flags unchanged.
- Illegal ops change no register or flag; done=1 and illegal=1 for one cycle.
- MUL (op 17, MUL_EN=1):
  - Edge k: capture |A|, |B| and the product sign; busy goes to 1.
  - Edges k+1..k+WIDTH: one unsigned shift-add step per edge into a 2*WIDTH-bit accumulator. |-2^(W-1)| fits in WIDTH unsigned bits.
  - Edge k+WIDTH: apply sign fix-up; Y<=low WIDTH bits of the signed product; busy goes to 0; done is high during the next cycle.
  - Total latency: WIDTH+1 cycles from accept to done.
  - Flags: V=1 when the 2*WIDTH-bit signed product does not fit in WIDTH signed bits; C=0; N/Z from Y.
  - A and B are not modified, and may be read by ALed/BLed throughout.
- Operand and selector changes while busy have no effect on the running multiply.
- enable held high continuously: a new op is accepted at every IDLE edge. Back-to-back single-cycle ops are therefore allowed, with done high every cycle.
- done and illegal are never high outside the single completion cycle.

Test Plan:
- Reset, then LDA 0x7F, LDB 0x01, ADD -> Y=0x80, flags N=1 Z=0 V=1 C=0; done is a 1-cycle pulse after each accept; ALed=0x7F, BLed=0x01.
- A=5, B=7, SUB -> Y=0xFE, N=1 V=0 C=0. Then A=B=7, SUB -> Y=0, Z=1, C=1.
- A=-3, B=7, MUL -> busy high for 8 cycles, done on cycle 9, Y=0xEB (-21), V=0. Then A=-128, B=-1, MUL -> Y=0x80, V=1.
- Start MUL, pulse enable with selector=0 during iterations 2 and 5 -> both ignored, with a single done and correct product. Repeat with reset low at iteration 4 -> Y=0, busy=0, no done pulse.
- A=3, B=-4: CMP -> Y=0x01; SWAP -> ALed=0xFC, BLed=0x03; MOVYA -> A=0x01; flags unchanged by SWAP/MOVYA.
- selector=20 -> done=1 and illegal=1 for one cycle, A/B/Y/flags unchanged. With MUL_EN=0, op 17 behaves the same and busy never asserts. With WIDTH=16, MUL 300x-200 -> Y=0x15A0 (low 16 bits of -60000), V=1, latency 17 cycles.

Source files
------------

// File: rtl/alu_seq_core.sv
// Clocked operand/result ALU with status flags and an iterative signed multiply.
// A, B and Y are registers. One operation runs per accepted enable strobe.
module alu_seq_core #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [4:0]       selector,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] ALed,
    output logic [WIDTH-1:0] BLed,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [3:0]       flags
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,  OP_SUB  = 5'd1,  OP_SHL  = 5'd2,  OP_SAR  = 5'd3,
        OP_CMP   = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_XOR  = 5'd7,
        OP_NAND  = 5'd8,  OP_NOR  = 5'd9,  OP_XNOR = 5'd10, OP_NOT  = 5'd11,
        OP_NEG   = 5'd12, OP_MOVYA = 5'd13, OP_SWAP = 5'd14, OP_LDA = 5'd15,
        OP_LDB   = 5'd16, OP_MUL  = 5'd17
    } op_e;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, y_q, y_d;
    logic [3:0]           flags_q, flags_d;
    logic                 done_q, done_d, ill_q, ill_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 neg_q, neg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 wr_y, v_res, c_res;
    logic [WIDTH-1:0]     y_res, abs_a, abs_b;
    logic [WIDTH:0]       sum, diff, prod_top;
    logic [2*WIDTH-1:0]   acc_nxt, prod;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        y_d      = y_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        ill_d    = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        wr_y     = 1'b0;
        y_res    = '0;
        v_res    = 1'b0;
        c_res    = 1'b0;
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        abs_a    = a_q[WIDTH-1] ? -a_q : a_q;
        abs_b    = b_q[WIDTH-1] ? -b_q : b_q;
        acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod     = neg_q ? -acc_nxt : acc_nxt;
        prod_top = prod[2*WIDTH-1:WIDTH-1];

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    done_d = 1'b1;
                    case (op_e'(selector))
                        OP_ADD: begin
                            wr_y  = 1'b1;
                            y_res = sum[WIDTH-1:0];
                            c_res = sum[WIDTH];
                            v_res = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
                        end
                        OP_SUB: begin
                            wr_y  = 1'b1;
                            y_res = diff[WIDTH-1:0];
                            c_res = ~diff[WIDTH];
                            v_res = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
                        end
                        OP_SHL: begin
                            wr_y  = 1'b1;
                            y_res = {a_q[WIDTH-2:0], 1'b0};
                            c_res = a_q[WIDTH-1];
                            v_res = a_q[WIDTH-1] ^ a_q[WIDTH-2];
                        end
                        OP_SAR: begin
                            wr_y  = 1'b1;
                            y_res = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                            c_res = a_q[0];
                        end
                        OP_CMP: begin
                            wr_y = 1'b1;
                            if (a_q == b_q)
                                y_res = '0;
                            else if ($signed(a_q) > $signed(b_q))
                                y_res = {{(WIDTH-1){1'b0}}, 1'b1};
                            else
                                y_res = '1;
                        end
                        OP_AND:  begin wr_y = 1'b1; y_res = a_q & b_q;    end
                        OP_OR:   begin wr_y = 1'b1; y_res = a_q | b_q;    end
                        OP_XOR:  begin wr_y = 1'b1; y_res = a_q ^ b_q;    end
                        OP_NAND: begin wr_y = 1'b1; y_res = ~(a_q & b_q); end
                        OP_NOR:  begin wr_y = 1'b1; y_res = ~(a_q | b_q); end
                        OP_XNOR: begin wr_y = 1'b1; y_res = ~(a_q ^ b_q); end
                        OP_NOT:  begin wr_y = 1'b1; y_res = ~a_q;         end
                        OP_NEG: begin
                            wr_y  = 1'b1;
                            y_res = -a_q;
                            v_res = (a_q == {1'b1, {(WIDTH-1){1'b0}}});
                        end
                        OP_MOVYA: a_d = y_q;
                        OP_SWAP: begin
                            a_d = b_q;
                            b_d = a_q;
                        end
                        OP_LDA: a_d = data_in;
                        OP_LDB: b_d = data_in;
                        OP_MUL: begin
                            if (MUL_EN) begin
                                // Magnitudes are unsigned WIDTH bits, so -2^(W-1) needs no extra bit.
                                done_d   = 1'b0;
                                state_d  = S_MUL;
                                mcand_d  = {{WIDTH{1'b0}}, abs_a};
                                mplier_d = abs_b;
                                acc_d    = '0;
                                neg_d    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                                cnt_d    = '0;
                            end else begin
                                ill_d = 1'b1;
                            end
                        end
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    y_d     = prod[WIDTH-1:0];
                    // Product fits in WIDTH signed bits only if the top W+1 bits are all equal.
                    flags_d = {prod[WIDTH-1], prod[WIDTH-1:0] == '0,
                               !((&prod_top) || !(|prod_top)), 1'b0};
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_y) begin
            y_d     = y_res;
            flags_d = {y_res[WIDTH-1], y_res == '0, v_res, c_res};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            ill_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            y_q      <= y_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            ill_q    <= ill_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Y       = y_q;
    assign ALed    = a_q;
    assign BLed    = b_q;
    assign busy    = (state_q == S_MUL);
    assign done    = done_q;
    assign illegal = ill_q;
    assign flags   = flags_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: directed vector table, multiply corner sequences and
// randomized ops checked against an integer-arithmetic reference model.
module tb_alu_seq_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  en;
    logic [4:0]  selector;
    logic [15:0] data_in;

    logic [7:0]  y8, a8, b8, ynm, anm, bnm;
    logic [15:0] y16, a16, b16;
    logic [3:0]  fl8, flnm, fl16;
    logic        busy8, done8, ill8, busynm, donenm, illnm, busy16, done16, ill16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq_core #(.WIDTH(8), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .enable(en[0]), .selector(selector), .data_in(data_in[7:0]),
        .Y(y8), .ALed(a8), .BLed(b8), .busy(busy8), .done(done8), .illegal(ill8), .flags(fl8));

    alu_seq_core #(.WIDTH(8), .MUL_EN(1'b0)) u_nomul (
        .clk(clk), .reset(reset), .enable(en[1]), .selector(selector), .data_in(data_in[7:0]),
        .Y(ynm), .ALed(anm), .BLed(bnm), .busy(busynm), .done(donenm), .illegal(illnm), .flags(flnm));

    alu_seq_core #(.WIDTH(16), .MUL_EN(1'b1)) u_w16 (
        .clk(clk), .reset(reset), .enable(en[2]), .selector(selector), .data_in(data_in),
        .Y(y16), .ALed(a16), .BLed(b16), .busy(busy16), .done(done16), .illegal(ill16), .flags(fl16));

    typedef struct {
        logic [4:0] sel;
        logic [7:0] din;
        logic [7:0] y;
        logic [3:0] fl;
        logic [7:0] a;
        logic [7:0] b;
        logic       ill;
        int         lat;
    } vec_t;

    vec_t tbl[$];

    logic [7:0] m_a, m_b, m_y;
    logic [3:0] m_fl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] sel, input logic [7:0] din, input logic [7:0] y,
                                input logic [3:0] fl, input logic [7:0] a, input logic [7:0] b,
                                input logic ill, input int lat);
        vec_t v;
        v.sel = sel; v.din = din; v.y = y; v.fl = fl; v.a = a; v.b = b; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    function automatic logic done_of(input int which);
        return (which == 0) ? done8 : (which == 1) ? donenm : done16;
    endfunction

    function automatic logic busy_of(input int which);
        return (which == 0) ? busy8 : (which == 1) ? busynm : busy16;
    endfunction

    function automatic logic ill_of(input int which);
        return (which == 0) ? ill8 : (which == 1) ? illnm : ill16;
    endfunction

    // Issue one strobe, measure cycles to done and cycles busy, then confirm done is a single pulse.
    task automatic run_op(input int which, input logic [4:0] sel, input logic [15:0] din,
                          output int lat, output int bcnt, output logic ill);
        @(negedge clk);
        selector  = sel;
        data_in   = din;
        en[which] = 1'b1;
        @(posedge clk);
        #1;
        en[which] = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!done_of(which) && lat < 40) begin
            if (busy_of(which)) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        ill = ill_of(which);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done_of(which)}, 32'd0);
        check("illegal_one_cycle", {31'd0, ill_of(which)}, 32'd0);
    endtask

    function automatic logic out_of_range(input int r);
        return (r > 127) || (r < -128);
    endfunction

    task automatic model_step(input int sel, input logic [7:0] din, output int lat, output logic ill);
        int sa, sb, ua, ub, r;
        logic v, c, wr;
        sa = int'($signed(m_a));
        sb = int'($signed(m_b));
        ua = int'(m_a);
        ub = int'(m_b);
        r = 0; v = 1'b0; c = 1'b0; wr = 1'b1;
        lat = 1;
        ill = 1'b0;
        case (sel)
            0:  begin r = sa + sb; v = out_of_range(r); c = (ua + ub) > 255; end
            1:  begin r = sa - sb; v = out_of_range(r); c = ua >= ub; end
            2:  begin r = sa * 2;  v = out_of_range(r); c = ua >= 128; end
            3:  begin r = (sa - ua % 2) / 2; c = (ua % 2) == 1; end
            4:  r = (sa == sb) ? 0 : (sa > sb) ? 1 : -1;
            5:  r = ua & ub;
            6:  r = ua | ub;
            7:  r = ua ^ ub;
            8:  r = ~(ua & ub);
            9:  r = ~(ua | ub);
            10: r = ~(ua ^ ub);
            11: r = ~ua;
            12: begin r = -sa; v = r > 127; end
            13: begin wr = 1'b0; m_a = m_y; end
            14: begin wr = 1'b0; m_a = m_b; m_b = 8'(ua); end
            15: begin wr = 1'b0; m_a = din; end
            16: begin wr = 1'b0; m_b = din; end
            17: begin r = sa * sb; v = out_of_range(r); lat = 9; end
            default: begin wr = 1'b0; ill = 1'b1; end
        endcase
        if (wr) begin
            m_y  = 8'(r);
            m_fl = {m_y[7], m_y == 8'd0, v, c};
        end
    endtask

    initial begin
        int lat, bcnt, elat, ndone, dpos;
        logic ill, eill;
        logic [4:0] sel;
        logic [7:0] din;

        en = '0; selector = '0; data_in = '0; reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_Y", {24'd0, y8}, 32'd0);
        check("rst_A", {24'd0, a8}, 32'd0);
        check("rst_B", {24'd0, b8}, 32'd0);
        check("rst_flags", {28'd0, fl8}, 32'd0);
        check("rst_busy_done_ill", {29'd0, busy8, done8, ill8}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        //            sel    din    y      fl     a      b      ill   lat
        tbl.push_back(mk(5'd15, 8'h7F, 8'h00, 4'h0, 8'h7F, 8'h00, 1'b0, 1));
        tbl.push_back(mk(5'd16, 8'h01, 8'h00, 4'h0, 8'h7F, 8'h01, 1'b0, 1));
        tbl.push_back(mk(5'd0,  8'h00, 8'h80, 4'hA, 8'h7F, 8'h01, 1'b0, 1));
        tbl.push_back(mk(5'd15, 8'h05, 8'h80, 4'hA, 8'h05, 8'h01, 1'b0, 1));
        tbl.push_back(mk(5'd16, 8'h07, 8'h80, 4'hA, 8'h05, 8'h07, 1'b0, 1));
        tbl.push_back(mk(5'd1,  8'h00, 8'hFE, 4'h8, 8'h05, 8'h07, 1'b0, 1));
        tbl.push_back(mk(5'd15, 8'h07, 8'hFE, 4'h8, 8'h07, 8'h07, 1'b0, 1));
        tbl.push_back(mk(5'd1,  8'h00, 8'h00, 4'h5, 8'h07, 8'h07, 1'b0, 1));
        tbl.push_back(mk(5'd15, 8'hFD, 8'h00, 4'h5, 8'hFD, 8'h07, 1'b0, 1));
        tbl.push_back(mk(5'd17, 8'h00, 8'hEB, 4'h8, 8'hFD, 8'h07, 1'b0, 9));
        tbl.push_back(mk(5'd15, 8'h80, 8'hEB, 4'h8, 8'h80, 8'h07, 1'b0, 1));
        tbl.push_back(mk(5'd16, 8'hFF, 8'hEB, 4'h8, 8'h80, 8'hFF, 1'b0, 1));
        tbl.push_back(mk(5'd17, 8'h00, 8'h80, 4'hA, 8'h80, 8'hFF, 1'b0, 9));
        tbl.push_back(mk(5'd15, 8'h03, 8'h80, 4'hA, 8'h03, 8'hFF, 1'b0, 1));
        tbl.push_back(mk(5'd16, 8'hFC, 8'h80, 4'hA, 8'h03, 8'hFC, 1'b0, 1));
        tbl.push_back(mk(5'd4,  8'h00, 8'h01, 4'h0, 8'h03, 8'hFC, 1'b0, 1));
        tbl.push_back(mk(5'd14, 8'h00, 8'h01, 4'h0, 8'hFC, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd13, 8'h00, 8'h01, 4'h0, 8'h01, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd20, 8'h55, 8'h01, 4'h0, 8'h01, 8'h03, 1'b1, 1));
        tbl.push_back(mk(5'd31, 8'h55, 8'h01, 4'h0, 8'h01, 8'h03, 1'b1, 1));
        tbl.push_back(mk(5'd15, 8'hC1, 8'h01, 4'h0, 8'hC1, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd2,  8'h00, 8'h82, 4'h9, 8'hC1, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd3,  8'h00, 8'hE0, 4'h9, 8'hC1, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd11, 8'h00, 8'h3E, 4'h0, 8'hC1, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd5,  8'h00, 8'h01, 4'h0, 8'hC1, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd6,  8'h00, 8'hC3, 4'h8, 8'hC1, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd7,  8'h00, 8'hC2, 4'h8, 8'hC1, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd8,  8'h00, 8'hFE, 4'h8, 8'hC1, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd9,  8'h00, 8'h3C, 4'h0, 8'hC1, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd10, 8'h00, 8'h3D, 4'h0, 8'hC1, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd15, 8'h80, 8'h3D, 4'h0, 8'h80, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd12, 8'h00, 8'h80, 4'hA, 8'h80, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd2,  8'h00, 8'h00, 4'h7, 8'h80, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd0,  8'h00, 8'h83, 4'h8, 8'h80, 8'h03, 1'b0, 1));
        tbl.push_back(mk(5'd1,  8'h00, 8'h7D, 4'h3, 8'h80, 8'h03, 1'b0, 1));

        foreach (tbl[i]) begin
            run_op(0, tbl[i].sel, {8'h00, tbl[i].din}, lat, bcnt, ill);
            check("vec_latency", lat, tbl[i].lat);
            check("vec_busy_cycles", bcnt, tbl[i].lat - 1);
            check("vec_illegal", {31'd0, ill}, {31'd0, tbl[i].ill});
            check("vec_Y", {24'd0, y8}, {24'd0, tbl[i].y});
            check("vec_flags", {28'd0, fl8}, {28'd0, tbl[i].fl});
            check("vec_ALed", {24'd0, a8}, {24'd0, tbl[i].a});
            check("vec_BLed", {24'd0, b8}, {24'd0, tbl[i].b});
        end

        // MUL_EN=0: op 17 is illegal and never raises busy
        run_op(1, 5'd15, 16'h0003, lat, bcnt, ill);
        run_op(1, 5'd16, 16'h0005, lat, bcnt, ill);
        run_op(1, 5'd17, 16'h0000, lat, bcnt, ill);
        check("nomul_latency", lat, 1);
        check("nomul_busy_cycles", bcnt, 0);
        check("nomul_illegal", {31'd0, ill}, 32'd1);
        check("nomul_Y", {24'd0, ynm}, 32'd0);
        check("nomul_flags", {28'd0, flnm}, 32'd0);
        check("nomul_AB", {16'd0, anm, bnm}, 32'h0305);

        // WIDTH=16: 300 * -200 = -60000, low half 0x15A0, overflow set
        run_op(2, 5'd15, 16'd300, lat, bcnt, ill);
        run_op(2, 5'd16, 16'hFF38, lat, bcnt, ill);
        run_op(2, 5'd17, 16'h0000, lat, bcnt, ill);
        check("w16_latency", lat, 17);
        check("w16_busy_cycles", bcnt, 16);
        check("w16_Y", {16'd0, y16}, 32'h15A0);
        check("w16_flags", {28'd0, fl16}, 32'h2);
        check("w16_AB_kept", {a16, b16}, {16'd300, 16'hFF38});

        // Enable pulses during iterations 2 and 5 must be ignored
        run_op(0, 5'd15, 16'h00FD, lat, bcnt, ill);
        run_op(0, 5'd16, 16'h0007, lat, bcnt, ill);
        @(negedge clk);
        selector = 5'd17;
        en[0] = 1'b1;
        @(posedge clk);
        #1;
        en[0] = 1'b0;
        selector = 5'd0;
        data_in = 16'h00AA;
        ndone = 0;
        dpos = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (done8) begin
                ndone++;
                if (dpos == 0) dpos = cyc;
            end
            en[0] = (cyc == 2 || cyc == 5);
            @(posedge clk);
            #1;
        end
        en[0] = 1'b0;
        check("ign_done_count", ndone, 1);
        check("ign_done_cycle", dpos, 9);
        check("ign_Y", {24'd0, y8}, 32'hEB);
        check("ign_flags", {28'd0, fl8}, 32'h8);
        check("ign_AB_kept", {16'd0, a8, b8}, 32'hFD07);

        // Reset during iteration 4 aborts the multiply with no done
        @(negedge clk);
        selector = 5'd17;
        en[0] = 1'b1;
        @(posedge clk);
        #1;
        en[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_Y", {24'd0, y8}, 32'd0);
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_AB", {16'd0, a8, b8}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) ndone++;
        end
        check("abort_no_done_after", ndone, 0);

        // Randomized ops against the reference model, starting from reset state
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_a = '0; m_b = '0; m_y = '0; m_fl = '0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                sel = ($urandom_range(0, 1) == 0) ? 5'd15 : 5'd16;
            else
                sel = 5'($urandom_range(0, 23));
            din = 8'($urandom);
            run_op(0, sel, {8'h00, din}, lat, bcnt, ill);
            model_step(int'(sel), din, elat, eill);
            check("rnd_latency", lat, elat);
            check("rnd_busy_cycles", bcnt, elat - 1);
            check("rnd_illegal", {31'd0, ill}, {31'd0, eill});
            check("rnd_Y", {24'd0, y8}, {24'd0, m_y});
            check("rnd_flags", {28'd0, fl8}, {28'd0, m_fl});
            check("rnd_AB", {16'd0, a8, b8}, {16'd0, m_a, m_b});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
